// File: rtl/cpu_core.sv
// cpu_core: single-cycle RV32 R-type core. Program counter, combinational
// instruction ROM, 32x32 register file, R-type decoder and 3-bit ALU.
// One register-register instruction retires on every rising clock edge.

// Combinational ALU; arithmetic wraps modulo 2^32 and no flags are produced.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_op,
    output logic [31:0] result
);

    // Select the operation; shift amounts use only the low five bits of b.
    always_comb begin
        result = 32'd0;
        case (alu_op)
            3'd0:    result = a + b;
            3'd1:    result = a - b;
            3'd2:    result = a & b;
            3'd3:    result = a | b;
            3'd4:    result = a ^ b;
            3'd5:    result = a << b[4:0];
            3'd6:    result = a >> b[4:0];
            3'd7:    result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: result = 32'd0;
        endcase
    end

endmodule

// Combinational instruction ROM; the byte offset is ignored and addresses
// beyond the depth wrap onto the low words.
module instruction_memory #(
    parameter int IMEM_WORDS = 64
) (
    input  logic [31:0] pc,
    output logic [31:0] instruction
);

    localparam int AW = $clog2(IMEM_WORDS);

    logic [AW-1:0] word_idx_s;
    logic [31:0]   word_idx_ext_s;
    logic          unused_pc_bits_s;

    assign word_idx_s       = pc[AW+1:2];
    assign word_idx_ext_s   = 32'(word_idx_s);
    assign unused_pc_bits_s = ^{pc[31:AW+2], pc[1:0]};

    // Fixed program: two real instructions, everything else a no-op add.
    always_comb begin
        instruction = 32'h0000_0033;
        case (word_idx_ext_s)
            32'd0:   instruction = 32'h0053_03B3; // add x7,x6,x5
            32'd1:   instruction = 32'h4084_8533; // sub x10,x9,x8
            default: instruction = 32'h0000_0033; // add x0,x0,x0
        endcase
    end

endmodule

module cpu_core #(
    parameter int IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out_check,
    output logic [31:0] instruction_check,
    output logic [2:0]  alu_op_check,
    output logic [31:0] register_data_out1_check,
    output logic [31:0] register_data_out2_check,
    output logic [31:0] register_data_in_check,
    output logic [31:0] alu_result_check
);

    logic [31:0] pc_r;
    logic [31:0] regs_r [0:31];

    logic [31:0] instr_s;
    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [6:0]  funct7_s;
    logic        we_s;
    logic [2:0]  alu_op_s;
    logic [31:0] rdata1_s;
    logic [31:0] rdata2_s;
    logic [31:0] alu_result_s;

    instruction_memory #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_imem (
        .pc          (pc_r),
        .instruction (instr_s)
    );

    assign opcode_s = instr_s[6:0];
    assign rd_s     = instr_s[11:7];
    assign funct3_s = instr_s[14:12];
    assign rs1_s    = instr_s[19:15];
    assign rs2_s    = instr_s[24:20];
    assign funct7_s = instr_s[31:25];

    // Decode R-type funct fields; anything unrecognised becomes a non-writing ADD.
    always_comb begin
        we_s     = 1'b0;
        alu_op_s = 3'd0;
        if (opcode_s == 7'b0110011) begin
            case (funct3_s)
                3'b000: begin
                    if (funct7_s == 7'b0000000) begin
                        we_s     = 1'b1;
                        alu_op_s = 3'd0;
                    end else if (funct7_s == 7'b0100000) begin
                        we_s     = 1'b1;
                        alu_op_s = 3'd1;
                    end else begin
                        we_s     = 1'b0;
                        alu_op_s = 3'd0;
                    end
                end
                3'b111:  begin we_s = 1'b1; alu_op_s = 3'd2; end
                3'b110:  begin we_s = 1'b1; alu_op_s = 3'd3; end
                3'b100:  begin we_s = 1'b1; alu_op_s = 3'd4; end
                3'b001:  begin we_s = 1'b1; alu_op_s = 3'd5; end
                3'b101:  begin we_s = 1'b1; alu_op_s = 3'd6; end
                3'b010:  begin we_s = 1'b1; alu_op_s = 3'd7; end
                default: begin we_s = 1'b0; alu_op_s = 3'd0; end
            endcase
        end else begin
            we_s     = 1'b0;
            alu_op_s = 3'd0;
        end
    end

    // Read ports: x0 is hard-wired to zero regardless of array contents.
    always_comb begin
        rdata1_s = 32'd0;
        rdata2_s = 32'd0;
        if (rs1_s != 5'd0) begin
            rdata1_s = regs_r[rs1_s];
        end else begin
            rdata1_s = 32'd0;
        end
        if (rs2_s != 5'd0) begin
            rdata2_s = regs_r[rs2_s];
        end else begin
            rdata2_s = 32'd0;
        end
    end

    alu u_alu (
        .a      (rdata1_s),
        .b      (rdata2_s),
        .alu_op (alu_op_s),
        .result (alu_result_s)
    );

    // Program counter: cleared asynchronously, otherwise advances one word per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= 32'd0;
        end else begin
            pc_r <= pc_r + 32'd4;
        end
    end

    // Register file: async restore to 3000+i, single write port, x0 never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_r[0] <= 32'd0;
            for (int i = 1; i < 32; i++) begin
                regs_r[i] <= 32'd3000 + 32'(i);
            end
        end else if (we_s && (rd_s != 5'd0)) begin
            regs_r[rd_s] <= alu_result_s;
        end
    end

    assign pc_out_check             = pc_r;
    assign instruction_check        = instr_s;
    assign alu_op_check             = alu_op_s;
    assign register_data_out1_check = rdata1_s;
    assign register_data_out2_check = rdata2_s;
    assign register_data_in_check   = alu_result_s;
    assign alu_result_check         = alu_result_s;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core plus standalone ALU and ROM vectors.
module tb_cpu_core;

    logic        clk;
    logic        reset;
    logic [31:0] pc_out_check;
    logic [31:0] instruction_check;
    logic [2:0]  alu_op_check;
    logic [31:0] register_data_out1_check;
    logic [31:0] register_data_out2_check;
    logic [31:0] register_data_in_check;
    logic [31:0] alu_result_check;

    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [2:0]  alu_op_s;
    logic [31:0] alu_res_s;
    logic [31:0] rom_pc_s;
    logic [31:0] rom_instr_s;

    int n_total;
    int n_bad;

    cpu_core #(.IMEM_WORDS(64)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .pc_out_check             (pc_out_check),
        .instruction_check        (instruction_check),
        .alu_op_check             (alu_op_check),
        .register_data_out1_check (register_data_out1_check),
        .register_data_out2_check (register_data_out2_check),
        .register_data_in_check   (register_data_in_check),
        .alu_result_check         (alu_result_check)
    );

    alu u_alu_tb (
        .a      (alu_a_s),
        .b      (alu_b_s),
        .alu_op (alu_op_s),
        .result (alu_res_s)
    );

    instruction_memory #(.IMEM_WORDS(64)) u_rom_tb (
        .pc          (rom_pc_s),
        .instruction (rom_instr_s)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] alu_exp [8];
    logic [31:0] rom_pcs [4];
    logic [31:0] rom_exp [4];

    initial begin
        n_total  = 0;
        n_bad    = 0;
        reset    = 1'b0;
        alu_a_s  = 32'd4;
        alu_b_s  = 32'd2;
        alu_op_s = 3'd0;
        rom_pc_s = 32'd0;

        // ALU with a=4, b=2 over all opcodes.
        alu_exp = '{32'd6, 32'd2, 32'd0, 32'd6, 32'd6, 32'd16, 32'd1, 32'd0};
        for (int op = 0; op < 8; op++) begin
            alu_op_s = 3'(op);
            #1;
            check_val($sformatf("alu_op%0d", op), alu_res_s, alu_exp[op]);
        end
        alu_a_s = 32'hFFFF_FFFF; alu_b_s = 32'd0; alu_op_s = 3'd7; #1;
        check_val("alu_slt_neg", alu_res_s, 32'd1);
        alu_a_s = 32'd0; alu_b_s = 32'd1; alu_op_s = 3'd1; #1;
        check_val("alu_sub_wrap", alu_res_s, 32'hFFFF_FFFF);
        alu_a_s = 32'd1; alu_b_s = 32'd33; alu_op_s = 3'd5; #1;
        check_val("alu_sll_b5", alu_res_s, 32'd2);
        alu_a_s = 32'h8000_0000; alu_b_s = 32'd31; alu_op_s = 3'd6; #1;
        check_val("alu_srl_logical", alu_res_s, 32'd1);

        // ROM lookups including address wrap and ignored byte offset.
        rom_pcs = '{32'd0, 32'd4, 32'd8, 32'd256};
        rom_exp = '{32'h0053_03B3, 32'h4084_8533, 32'h0000_0033, 32'h0053_03B3};
        for (int k = 0; k < 4; k++) begin
            rom_pc_s = rom_pcs[k];
            #1;
            check_val($sformatf("rom_pc%0d", rom_pcs[k]), rom_instr_s, rom_exp[k]);
        end
        rom_pc_s = 32'd7; #1;
        check_val("rom_byteoff", rom_instr_s, 32'h4084_8533);

        // Reset pulse then release between edges.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_pc", pc_out_check, 32'd0);
        check_val("rst_instr", instruction_check, 32'h0053_03B3);
        check_val("rst_aluop", 32'(alu_op_check), 32'd0);
        check_val("rst_out1", register_data_out1_check, 32'd3006);
        check_val("rst_out2", register_data_out2_check, 32'd3005);
        check_val("rst_result", alu_result_check, 32'd6011);
        check_val("rst_datain", register_data_in_check, 32'd6011);

        // First edge: add x7 retires, sub x10 is now presented.
        @(posedge clk); #1;
        check_val("e1_pc", pc_out_check, 32'd4);
        check_val("e1_instr", instruction_check, 32'h4084_8533);
        check_val("e1_aluop", 32'(alu_op_check), 32'd1);
        check_val("e1_out1", register_data_out1_check, 32'd3009);
        check_val("e1_out2", register_data_out2_check, 32'd3008);
        check_val("e1_result", alu_result_check, 32'd1);
        check_val("e1_x7", dut.regs_r[7], 32'd6011);

        // Second edge: no-op add x0,x0,x0.
        @(posedge clk); #1;
        check_val("e2_pc", pc_out_check, 32'd8);
        check_val("e2_instr", instruction_check, 32'h0000_0033);
        check_val("e2_out1", register_data_out1_check, 32'd0);
        check_val("e2_result", alu_result_check, 32'd0);
        check_val("e2_x10", dut.regs_r[10], 32'd1);
        @(posedge clk); #1;
        check_val("e3_x0", dut.regs_r[0], 32'd0);
        check_val("e3_out2", register_data_out2_check, 32'd0);
        @(posedge clk); #1;
        check_val("e4_pc", pc_out_check, 32'd16);
        check_val("e4_x7", dut.regs_r[7], 32'd6011);

        // Mid-cycle reset: state restored with no clock edge.
        #2;
        reset = 1'b0;
        #1;
        check_val("mid_pc", pc_out_check, 32'd0);
        check_val("mid_x7", dut.regs_r[7], 32'd3007);
        check_val("mid_x10", dut.regs_r[10], 32'd3010);
        check_val("mid_instr", instruction_check, 32'h0053_03B3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rel_pc", pc_out_check, 32'd4);
        check_val("rel_x7", dut.regs_r[7], 32'd6011);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
